// File: rtl/cpu_types_pkg.sv
// Shared datapath types plus the writeback-source encoding.
package cpu_types_pkg;
  localparam int WORD_W = 32;
  localparam int REG_W  = 5;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  regbits_t;

  // Writeback source select carried in MemtoReg.
  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_NPC = 2'd2,
    WB_EXT = 2'd3
  } wbsrc_t;

  localparam int LINK_REG_DEFAULT = 31;
endpackage

// File: rtl/wb_commit_unit_if.sv
// MEM/WB latch outputs as seen by the writeback stage.
interface wb_commit_unit_if;
  import cpu_types_pkg::*;

  logic       valid_i;
  word_t      npc_i;
  word_t      aluout_i;
  word_t      dload_i;
  word_t      extout_i;
  logic [1:0] MemtoReg_i;
  logic       RegDst_i;
  logic       RegWrite_i;
  logic       halt_i;
  regbits_t   rt_i;
  regbits_t   rd_i;

  // Latch side drives, commit unit consumes.
  modport master (
    output valid_i, npc_i, aluout_i, dload_i, extout_i,
           MemtoReg_i, RegDst_i, RegWrite_i, halt_i, rt_i, rd_i
  );
  modport slave (
    input  valid_i, npc_i, aluout_i, dload_i, extout_i,
           MemtoReg_i, RegDst_i, RegWrite_i, halt_i, rt_i, rd_i
  );
endinterface

// File: rtl/wb_commit_unit_mux.sv
// Combinational writeback word and destination register selection.
module wb_mux
  import cpu_types_pkg::*;
#(
  parameter int LINK_REG = LINK_REG_DEFAULT
) (
  input  wbsrc_t   src,
  input  logic     reg_dst,
  input  regbits_t rt,
  input  regbits_t rd,
  input  word_t    npc,
  input  word_t    aluout,
  input  word_t    dload,
  input  word_t    extout,
  output regbits_t wsel,
  output word_t    wdat
);
  // Link writes always target the link register, regardless of reg_dst.
  always_comb begin
    wsel = reg_dst ? rd : rt;
    wdat = aluout;
    case (src)
      WB_ALU: wdat = aluout;
      WB_MEM: wdat = dload;
      WB_NPC: begin
        wdat = npc;
        wsel = regbits_t'(LINK_REG);
      end
      WB_EXT: wdat = extout;
      default: wdat = aluout;
    endcase
  end
endmodule

// File: rtl/wb_commit_unit.sv
// Writeback/commit: drives the regfile write port, keeps a one-cycle
// forwarding record, a sticky halt flag and a saturating retire counter.
module wb_commit_unit
  import cpu_types_pkg::*;
#(
  parameter int RETIRE_W = 32,
  parameter int LINK_REG = LINK_REG_DEFAULT
) (
  input  logic                CLK,
  input  logic                RST,
  wb_commit_unit_if.slave     lat,
  output logic                WEN,
  output regbits_t            wsel,
  output word_t               wdat,
  output logic                fwd_valid,
  output regbits_t            fwd_reg,
  output word_t               fwd_dat,
  output logic                halt,
  output logic [RETIRE_W-1:0] retired
);
  logic commit;
  logic retire;

  wb_mux #(.LINK_REG(LINK_REG)) u_mux (
    .src     (wbsrc_t'(lat.MemtoReg_i)),
    .reg_dst (lat.RegDst_i),
    .rt      (lat.rt_i),
    .rd      (lat.rd_i),
    .npc     (lat.npc_i),
    .aluout  (lat.aluout_i),
    .dload   (lat.dload_i),
    .extout  (lat.extout_i),
    .wsel    (wsel),
    .wdat    (wdat)
  );

  // Commit qualification; HALT itself never writes and r0 is never written.
  always_comb begin
    commit = lat.valid_i & ~halt;
    retire = commit & ~lat.halt_i;
    WEN    = ~RST & retire & lat.RegWrite_i & (wsel != '0);
  end

  // Halt flag, saturating retire count and forwarding record.
  always_ff @(posedge CLK) begin
    if (RST) begin
      halt      <= 1'b0;
      retired   <= '0;
      fwd_valid <= 1'b0;
      fwd_reg   <= '0;
      fwd_dat   <= '0;
    end else begin
      if (commit & lat.halt_i) halt <= 1'b1;
      if (retire && retired != {RETIRE_W{1'b1}}) retired <= retired + RETIRE_W'(1);
      fwd_valid <= WEN;
      if (WEN) begin
        fwd_reg <= wsel;
        fwd_dat <= wdat;
      end
    end
  end
endmodule

// File: tb/tb_wb_commit_unit.sv
// Directed bench with a per-cycle reference model of the commit rules.
module tb_wb_commit_unit;
  import cpu_types_pkg::*;

  localparam int RW = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic          WEN, fwd_valid, halt;
  regbits_t      wsel, fwd_reg;
  word_t         wdat, fwd_dat;
  logic [RW-1:0] retired;

  wb_commit_unit_if lat();

  wb_commit_unit #(.RETIRE_W(RW), .LINK_REG(31)) dut (
    .CLK(CLK), .RST(RST), .lat(lat.slave),
    .WEN(WEN), .wsel(wsel), .wdat(wdat),
    .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_dat(fwd_dat),
    .halt(halt), .retired(retired)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference state: what the architectural record should hold.
  logic     m_halt;
  int       m_ret;
  logic     m_fv;
  regbits_t m_fr;
  word_t    m_fd;

  function automatic regbits_t ref_dest();
    if (lat.MemtoReg_i == 2'd2) return regbits_t'(31);
    return lat.RegDst_i ? lat.rd_i : lat.rt_i;
  endfunction

  function automatic word_t ref_data();
    case (lat.MemtoReg_i)
      2'd0: return lat.aluout_i;
      2'd1: return lat.dload_i;
      2'd2: return lat.npc_i;
      default: return lat.extout_i;
    endcase
  endfunction

  function automatic logic ref_counts();
    return lat.valid_i && !m_halt && !lat.halt_i;
  endfunction

  function automatic logic ref_wen();
    return !RST && ref_counts() && lat.RegWrite_i && ref_dest() != 0;
  endfunction

  // Advance the model on each edge.
  always @(posedge CLK) begin
    if (RST) begin
      m_halt <= 1'b0; m_ret <= 0; m_fv <= 1'b0; m_fr <= '0; m_fd <= '0;
    end else begin
      if (lat.valid_i && !m_halt && lat.halt_i) m_halt <= 1'b1;
      if (ref_counts()) m_ret <= (m_ret < (1 << RW) - 1) ? m_ret + 1 : m_ret;
      m_fv <= ref_wen();
      if (ref_wen()) begin
        m_fr <= ref_dest();
        m_fd <= ref_data();
      end
    end
  end

  // Compare every output against the model mid-cycle.
  always @(negedge CLK) begin
    if (chk_en) begin
      check("WEN", 32'(WEN), 32'(ref_wen()));
      check("wsel", 32'(wsel), 32'(ref_dest()));
      check("wdat", wdat, ref_data());
      check("fwd_valid", 32'(fwd_valid), 32'(m_fv));
      check("fwd_reg", 32'(fwd_reg), 32'(m_fr));
      check("fwd_dat", fwd_dat, m_fd);
      check("halt", 32'(halt), 32'(m_halt));
      check("retired", 32'(retired), 32'(m_ret));
    end
  end

  task automatic idle();
    lat.valid_i = 0; lat.npc_i = '0; lat.aluout_i = '0; lat.dload_i = '0;
    lat.extout_i = '0; lat.MemtoReg_i = 2'd0; lat.RegDst_i = 0;
    lat.RegWrite_i = 0; lat.halt_i = 0; lat.rt_i = '0; lat.rd_i = '0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic alu_wr(input int r, input logic [31:0] v);
    idle();
    lat.valid_i = 1; lat.RegWrite_i = 1; lat.RegDst_i = 1;
    lat.rd_i = regbits_t'(r); lat.aluout_i = v;
  endtask

  initial begin
    idle();
    RST = 1;
    // Reset held two cycles with a live write presented.
    alu_wr(3, 32'h5);
    #1 check("rst_wen0", 32'(WEN), 32'd0);
    tick();
    chk_en = 1'b1;
    check("rst_wen1", 32'(WEN), 32'd0);
    tick();
    RST = 0;
    idle();
    #1;
    check("rst_halt", 32'(halt), 32'd0);
    check("rst_retired", 32'(retired), 32'd0);
    check("rst_fwd_valid", 32'(fwd_valid), 32'd0);
    tick();

    // ALU write to rd=5.
    alu_wr(5, 32'h0000_1234);
    #1;
    check("alu_wen", 32'(WEN), 32'd1);
    check("alu_wsel", 32'(wsel), 32'd5);
    check("alu_wdat", wdat, 32'h1234);
    tick();
    idle();
    check("alu_fwd_valid", 32'(fwd_valid), 32'd1);
    check("alu_fwd_reg", 32'(fwd_reg), 32'd5);
    check("alu_fwd_dat", fwd_dat, 32'h1234);
    check("alu_retired", 32'(retired), 32'd1);

    // JAL: link register regardless of RegDst.
    idle();
    lat.valid_i = 1; lat.RegWrite_i = 1; lat.MemtoReg_i = 2'd2;
    lat.RegDst_i = 0; lat.rt_i = 5'd7; lat.npc_i = 32'h40;
    #1;
    check("jal_wsel", 32'(wsel), 32'd31);
    check("jal_wdat", wdat, 32'h40);
    check("jal_wen", 32'(WEN), 32'd1);
    tick();
    // LW into r0: suppressed but counted.
    idle();
    lat.valid_i = 1; lat.RegWrite_i = 1; lat.MemtoReg_i = 2'd1;
    lat.rt_i = 5'd0; lat.dload_i = 32'hDEAD_BEEF;
    #1;
    check("lw_r0_wen", 32'(WEN), 32'd0);
    check("lw_r0_wdat", wdat, 32'hDEAD_BEEF);
    check("jal_retired", 32'(retired), 32'd2);
    tick();
    idle();
    check("lw_retired", 32'(retired), 32'd3);
    check("lw_fwd_valid", 32'(fwd_valid), 32'd0);
    check("lw_fwd_reg_held", 32'(fwd_reg), 32'd31);
    check("lw_fwd_dat_held", fwd_dat, 32'h40);

    // Bubble carrying halt_i is ignored.
    lat.valid_i = 0; lat.halt_i = 1; lat.RegWrite_i = 1; lat.RegDst_i = 1; lat.rd_i = 5'd4;
    #1 check("bub_wen", 32'(WEN), 32'd0);
    tick();
    idle();
    check("bub_halt", 32'(halt), 32'd0);
    check("bub_retired", 32'(retired), 32'd3);
    check("bub_fwd_valid", 32'(fwd_valid), 32'd0);

    // Fresh start, three writes, HALT, then two writes that must be blocked.
    RST = 1; tick(); RST = 0;
    for (int i = 1; i <= 3; i++) begin
      alu_wr(i, 32'h100 + 32'(i));
      tick();
    end
    idle();
    lat.valid_i = 1; lat.halt_i = 1; lat.RegWrite_i = 1; lat.RegDst_i = 1; lat.rd_i = 5'd8;
    #1 check("halt_instr_wen", 32'(WEN), 32'd0);
    tick();
    check("halt_set", 32'(halt), 32'd1);
    check("halt_retired", 32'(retired), 32'd3);
    for (int i = 0; i < 2; i++) begin
      alu_wr(9 + i, 32'hABC0 + 32'(i));
      #1 check("post_halt_wen", 32'(WEN), 32'd0);
      tick();
    end
    idle();
    check("halt_frozen_ret", 32'(retired), 32'd3);
    check("halt_fwd_valid", 32'(fwd_valid), 32'd0);
    check("halt_sticky", 32'(halt), 32'd1);
    RST = 1; tick(); RST = 0;
    check("rst_clr_halt", 32'(halt), 32'd0);
    check("rst_clr_ret", 32'(retired), 32'd0);

    // Saturation of the 4-bit counter; mix writes and non-writes.
    for (int i = 0; i < 17; i++) begin
      alu_wr((i % 6) + 1, 32'h2000 + 32'(i));
      lat.RegWrite_i = i[0];
      tick();
    end
    idle();
    check("sat_15", 32'(retired), 32'd15);
    alu_wr(2, 32'h77);
    tick();
    idle();
    check("sat_hold", 32'(retired), 32'd15);
    check("sat_fwd_dat", fwd_dat, 32'h77);
    tick();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
